// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if
//   Handshake bundle for sync_fifo_prog.
//   master: producer/consumer side (drives wr_en, wr_data, rd_en).
//   slave : FIFO side (drives data-out, flags, error pulses, count).
//   Signals: wr_en, wr_data[W], full, afull, overflow,
//            rd_en, rd_data[W], rd_valid, empty, aempty, underflow,
//            count[AW+1].
interface sync_fifo_prog_if #(
  parameter int W     = 8,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          full;
  logic          afull;
  logic          overflow;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic          empty;
  logic          aempty;
  logic          underflow;
  logic [AW:0]   count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, afull, overflow, rd_data, rd_valid, empty, aempty, underflow, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, afull, overflow, rd_data, rd_valid, empty, aempty, underflow, count
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog
//   Single-clock FIFO with programmable almost-full/almost-empty thresholds,
//   occupancy count and registered overflow/underflow pulses.
//   Ports:
//     clk   : clock, all logic on posedge
//     reset : synchronous active-high reset (memory contents are kept)
//     fifo  : sync_fifo_prog_if.slave (write side, read side, flags, count)
//   Build option:
//     SYNC_FIFO_FWFT_EN defined   -> first-word-fall-through read port
//                                    (rd_data = mem[rd_ptr], rd_valid = !empty)
//     SYNC_FIFO_FWFT_EN undefined -> registered read port, 1-cycle latency
module sync_fifo_prog #(
  parameter int W         = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            reset,
  sync_fifo_prog_if.slave fifo
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_C  = AFULL_TH[AW:0];
  localparam logic [AW:0] AEMPTY_C = AEMPTY_TH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, underflow_q;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  // All flags decode from the registered count.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  assign wr_acc = fifo.wr_en & ~full;
  assign rd_acc = fifo.rd_en & ~empty;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr_q] <= fifo.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= fifo.wr_en & full;
      underflow_q <= fifo.rd_en & empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign fifo.rd_data  = mem[rd_ptr_q];
  assign fifo.rd_valid = ~empty;
`else
  logic [W-1:0] rd_data_q;
  logic         rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
      rd_valid_q <= rd_acc;
    end
  end

  assign fifo.rd_data  = rd_data_q;
  assign fifo.rd_valid = rd_valid_q;
`endif

  assign fifo.full      = full;
  assign fifo.empty     = empty;
  assign fifo.afull     = (count_q >= AFULL_C);
  assign fifo.aempty    = (count_q <= AEMPTY_C);
  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;
  assign fifo.count     = count_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog
//   Self-checking bench for sync_fifo_prog (W=8, DEPTH=16, default thresholds).
//   Works in both read modes, following SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_prog;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  sync_fifo_prog_if #(.W(W), .DEPTH(DEPTH)) fifo ();

  sync_fifo_prog #(.W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .fifo  (fifo.slave)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned mcnt        = 0;
  logic [W-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Flags, count and pulses against the bench's own occupancy model.
  task automatic check_flags(input logic exp_ovf, input logic exp_unf);
    check("count",     32'(fifo.count),     mcnt);
    check("full",      32'(fifo.full),      32'(mcnt == DEPTH));
    check("empty",     32'(fifo.empty),     32'(mcnt == 0));
    check("afull",     32'(fifo.afull),     32'(mcnt >= DEPTH - 2));
    check("aempty",    32'(fifo.aempty),    32'(mcnt <= 2));
    check("overflow",  32'(fifo.overflow),  32'(exp_ovf));
    check("underflow", 32'(fifo.underflow), 32'(exp_unf));
  endtask

  // One clock of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cycle(input logic we, input logic [W-1:0] wd, input logic re);
    logic wa, ra, ovf, unf;
    logic [W-1:0] exp_d;
    exp_d = '0;
    fifo.wr_en   = we;
    fifo.wr_data = wd;
    fifo.rd_en   = re;
    wa  = we && (mcnt != DEPTH);
    ra  = re && (mcnt != 0);
    ovf = we && (mcnt == DEPTH);
    unf = re && (mcnt == 0);
    if (ra) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'(sb.size()), 32'd1);
      end else begin
        exp_d = sb.pop_front();
      end
`ifdef SYNC_FIFO_FWFT_EN
      check("fwft_valid", 32'(fifo.rd_valid), 32'd1);
      check("fwft_data",  32'(fifo.rd_data),  32'(exp_d));
`endif
    end
    if (wa) sb.push_back(wd);
    if (wa && !ra) mcnt++;
    if (ra && !wa) mcnt--;
    @(posedge clk);
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid", 32'(fifo.rd_valid), 32'(mcnt != 0));
`else
    check("rd_valid", 32'(fifo.rd_valid), 32'(ra));
    if (ra) check("rd_data", 32'(fifo.rd_data), 32'(exp_d));
`endif
    check_flags(ovf, unf);
    fifo.wr_en = 1'b0;
    fifo.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo.wr_en = 1'b0;
    fifo.rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mcnt  = 0;
    sb.delete();
    check_flags(1'b0, 1'b0);
    check("rst_rd_valid", 32'(fifo.rd_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rd_data", 32'(fifo.rd_data), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    fifo.wr_en   = 1'b0;
    fifo.wr_data = '0;
    fifo.rd_en   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill 0x00..0x0F; afull after the 14th, full after the 16th.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, W'(i), 1'b0);
    // Write at full is dropped and pulses overflow.
    cycle(1'b1, 8'hAA, 1'b0);
    // Drain in order; 0xAA must never appear.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
    // Read while empty pulses underflow.
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Fill to 5, then simultaneous read/write across several wraps.
    for (int i = 0; i < 5; i++) cycle(1'b1, W'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, W'(8'h25 + i), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);

    // Simultaneous read/write while empty: write taken, read flagged.
    cycle(1'b1, 8'h3C, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Reset mid-stream discards contents.
    for (int i = 0; i < 9; i++) cycle(1'b1, W'(8'h80 + i), 1'b0);
    do_reset();
    cycle(1'b1, 8'h55, 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
